pe_feeder: RTL and testbench

- Upstream sequencer for a single PE.
- Reads one weight kernel and one activation tile from a global buffer (GLB) synchronous read port, and streams them into the PE load interface as gap-free bursts.
- Then issues one start per output row, ACT_SIZE-KERNEL_SIZE+1 starts in total, and captures each pe_out result into a small output FIFO.
- Sits between the GLB/router and the PE; one instance per PE in the cluster.

---
 rtl/pe_feeder_pkg.sv | 36 +++
 rtl/pe_feeder_sync_fifo.sv | 57 +++++
 rtl/pe_feeder.sv | 185 ++++++++++++++++++
 tb/tb_pe_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared types and geometry helpers for the PE feeder.
package pe_feeder_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_RD,
    W_WAIT,
    GAP_W,
    A_RD,
    A_WAIT,
    GAP_A,
    START,
    C_WAIT,
    GAP_C,
    DONE
  } state_e;

  // Default geometry: 3x3 kernel over a 5x5 activation tile.
  localparam int DFLT_KERNEL_SIZE = 3;
  localparam int DFLT_ACT_SIZE    = 5;

  // Words in a square burst of the given edge length.
  function automatic int burst_words(input int edge_len);
    return edge_len * edge_len;
  endfunction

  // Output rows produced by one activation load.
  function automatic int out_rows(input int act_edge, input int kern_edge);
    return act_edge - kern_edge + 1;
  endfunction

  localparam int W_WORDS = burst_words(DFLT_KERNEL_SIZE);
  localparam int A_WORDS = burst_words(DFLT_ACT_SIZE);
  localparam int N_ROWS  = out_rows(DFLT_ACT_SIZE, DFLT_KERNEL_SIZE);

endpackage

// File: rtl/pe_feeder_sync_fifo.sv
// Small synchronous FIFO with a combinational head; head reads 0 when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage write port, kept free of reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Sequences weight/activation bursts from the GLB into one PE, issues one start
// per output row and buffers the row results.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int GLB_ADDR_WIDTH = 12,
  parameter int KERNEL_SIZE    = DFLT_KERNEL_SIZE,
  parameter int ACT_SIZE       = DFLT_ACT_SIZE,
  parameter int OUT_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [GLB_ADDR_WIDTH-1:0] cmd_wght_base,
  input  logic [GLB_ADDR_WIDTH-1:0] cmd_act_base,
  input  logic                      cmd_reuse_wght,
  output logic                      glb_rd_en,
  output logic [GLB_ADDR_WIDTH-1:0] glb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     glb_rd_data,
  output logic [DATA_WIDTH-1:0]     pe_filt_in,
  output logic [DATA_WIDTH-1:0]     pe_act_in,
  output logic                      pe_load_en_wght,
  output logic                      pe_load_en_act,
  output logic                      pe_start,
  input  logic                      pe_load_done,
  input  logic                      pe_compute_done,
  input  logic [DATA_WIDTH-1:0]     pe_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_WIDTH-1:0]     res_data,
  output logic                      busy,
  output logic                      cmd_done
);

  localparam int NUM_W    = burst_words(KERNEL_SIZE);
  localparam int NUM_A    = burst_words(ACT_SIZE);
  localparam int NUM_ROWS = out_rows(ACT_SIZE, KERNEL_SIZE);
  localparam int CNT_W    = $clog2(((NUM_A > NUM_W) ? NUM_A : NUM_W) + 1);
  localparam int ROW_W    = $clog2(NUM_ROWS + 1);

  state_e                    state_q, state_d;
  logic [GLB_ADDR_WIDTH-1:0] wbase_q, abase_q;
  logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic                      wloaded_q, wloaded_d;
  logic                      ld_prev_q, cd_prev_q;
  logic                      wpulse_q, apulse_q;
  logic                      wvld_q, avld_q;
  logic                      ld_rise, cd_rise;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign ld_rise         = pe_load_done && !ld_prev_q;
  assign cd_rise         = pe_compute_done && !cd_prev_q;
  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign pe_load_en_wght = wpulse_q;
  assign pe_load_en_act  = apulse_q;
  // Read data is passed straight through while its burst is returning.
  assign pe_filt_in      = wvld_q ? glb_rd_data : '0;
  assign pe_act_in       = avld_q ? glb_rd_data : '0;
  assign res_valid       = !fifo_empty;
  assign fifo_pop        = res_valid && res_ready;

  // Next-state, GLB read and PE request decode.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    row_cnt_d   = row_cnt_q;
    wloaded_d   = wloaded_q;
    glb_rd_en   = 1'b0;
    glb_rd_addr = '0;
    pe_start    = 1'b0;
    fifo_push   = 1'b0;
    cmd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        // Reuse is only honoured once the PE really holds a kernel.
        if (cmd_valid) state_d = (cmd_reuse_wght && wloaded_q) ? A_RD : W_RD;
      end
      W_RD: begin
        glb_rd_en   = 1'b1;
        glb_rd_addr = wbase_q + GLB_ADDR_WIDTH'(rd_cnt_q);
        if (rd_cnt_q == CNT_W'(NUM_W - 1)) begin
          rd_cnt_d = '0;
          state_d  = W_WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      W_WAIT: begin
        if (ld_rise) begin
          wloaded_d = 1'b1;
          state_d   = GAP_W;
        end
      end
      GAP_W:  if (!pe_load_done) state_d = A_RD;
      A_RD: begin
        glb_rd_en   = 1'b1;
        glb_rd_addr = abase_q + GLB_ADDR_WIDTH'(rd_cnt_q);
        if (rd_cnt_q == CNT_W'(NUM_A - 1)) begin
          rd_cnt_d = '0;
          state_d  = A_WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      A_WAIT: if (ld_rise) state_d = GAP_A;
      GAP_A:  if (!pe_load_done) state_d = START;
      START: begin
        // Never start a row whose result would have nowhere to land.
        if (!fifo_full) begin
          pe_start = 1'b1;
          state_d  = C_WAIT;
        end
      end
      C_WAIT: begin
        if (cd_rise) begin
          fifo_push = 1'b1;
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = GAP_C;
        end
      end
      GAP_C: begin
        if (!pe_compute_done) state_d = (row_cnt_q < ROW_W'(NUM_ROWS)) ? START : DONE;
      end
      DONE: begin
        cmd_done  = 1'b1;
        row_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, latched bases, done-edge history and burst pulse timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wbase_q   <= '0;
      abase_q   <= '0;
      rd_cnt_q  <= '0;
      row_cnt_q <= '0;
      wloaded_q <= 1'b0;
      ld_prev_q <= 1'b0;
      cd_prev_q <= 1'b0;
      wpulse_q  <= 1'b0;
      apulse_q  <= 1'b0;
      wvld_q    <= 1'b0;
      avld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      row_cnt_q <= row_cnt_d;
      wloaded_q <= wloaded_d;
      ld_prev_q <= pe_load_done;
      cd_prev_q <= pe_compute_done;
      if (state_q == IDLE && cmd_valid) begin
        wbase_q <= cmd_wght_base;
        abase_q <= cmd_act_base;
      end
      // Word 0 returns one cycle after the first read; the pulse marks it.
      wpulse_q <= (state_q == W_RD) && (rd_cnt_q == '0);
      apulse_q <= (state_q == A_RD) && (rd_cnt_q == '0);
      wvld_q   <= (state_q == W_RD);
      avld_q   <= (state_q == A_RD);
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUT_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pe_out),
    .pop       (fifo_pop),
    .pop_data  (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: GLB memory model, simplified PE model, result scoreboard.
module tb_pe_feeder;

  localparam int DW = 16, AW = 12, K = 3, A = 5, OD = 2;
  localparam int KW = K * K, AWD = A * A, NR = A - K + 1;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_reuse_wght = 1'b0;
  logic [AW-1:0] cmd_wght_base = '0, cmd_act_base = '0;
  logic          glb_rd_en;
  logic [AW-1:0] glb_rd_addr;
  logic [DW-1:0] glb_rd_data = '0;
  logic [DW-1:0] pe_filt_in, pe_act_in, pe_out = '0, res_data;
  logic          pe_load_en_wght, pe_load_en_act, pe_start;
  logic          pe_load_done = 1'b0, pe_compute_done = 1'b0;
  logic          res_valid, res_ready = 1'b1, busy, cmd_done;

  pe_feeder #(.DATA_WIDTH(DW), .GLB_ADDR_WIDTH(AW), .KERNEL_SIZE(K),
              .ACT_SIZE(A), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wght_base(cmd_wght_base), .cmd_act_base(cmd_act_base),
    .cmd_reuse_wght(cmd_reuse_wght), .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr),
    .glb_rd_data(glb_rd_data), .pe_filt_in(pe_filt_in), .pe_act_in(pe_act_in),
    .pe_load_en_wght(pe_load_en_wght), .pe_load_en_act(pe_load_en_act),
    .pe_start(pe_start), .pe_load_done(pe_load_done), .pe_compute_done(pe_compute_done),
    .pe_out(pe_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .cmd_done(cmd_done));

  always #5 clk = ~clk;

  // GLB: synchronous read, data one cycle after the request.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) if (glb_rd_en) glb_rd_data <= mem[glb_rd_addr];

  int checks = 0, failures = 0;
  task automatic chk(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Monitor / PE model state.
  int cyc = 0, w_win = 0, a_win = 0, w_idx = 0, a_idx = 0;
  int ld_timer = 0, ld_hold = 0, c_timer = 0, c_hold = 0, pe_row = 0;
  bit stuck_en = 1'b0;
  logic [DW-1:0] pe_w [KW];
  logic [DW-1:0] pe_a [AWD];
  int rd_addr_q[$], rd_cyc_q[$], wp_cyc[$], ap_cyc[$];
  int n_start = 0, n_done = 0;
  logic [DW-1:0] exp_q[$], res_log[$];

  // Scoreboard side: the kernel the PE should hold and the expected results.
  int tb_wk [KW];
  bit wk_valid = 1'b0;
  int cur_wb, cur_ab;
  bit cur_eff;

  // The simplified PE: row r = dot(first kernel row, first K words of activation row r).
  function automatic logic [DW-1:0] exp_row(input int ab, input int r);
    int s = 0;
    for (int j = 0; j < K; j++) s += tb_wk[j] * int'(mem[ab + r * A + j]);
    return s[DW-1:0];
  endfunction

  // Per-cycle monitor, PE behaviour and result check, all on the falling edge.
  always @(negedge clk) begin
    int s;
    cyc++;
    if (reset) begin
      w_win = 0; a_win = 0; ld_timer = 0; ld_hold = 0; c_timer = 0; c_hold = 0; pe_row = 0;
      pe_load_done = 1'b0; pe_compute_done = 1'b0; pe_out = '0;
    end else begin
      chk("one_pe_request", ($countones({pe_load_en_wght, pe_load_en_act, pe_start}) <= 1), 1);
      if (glb_rd_en) begin rd_addr_q.push_back(int'(glb_rd_addr)); rd_cyc_q.push_back(cyc); end
      if (pe_load_en_wght) begin wp_cyc.push_back(cyc); w_win = KW; w_idx = 0; end
      if (pe_load_en_act)  begin ap_cyc.push_back(cyc); a_win = AWD; a_idx = 0; pe_row = 0; end
      if (pe_start) n_start++;
      if (cmd_done) n_done++;
      if (w_win > 0) begin
        pe_w[w_idx] = pe_filt_in; w_idx++; w_win--;
        if (w_win == 0) ld_timer = 3;
      end else chk("filt_idle_zero", pe_filt_in, 0);
      if (a_win > 0) begin
        pe_a[a_idx] = pe_act_in; a_idx++; a_win--;
        if (a_win == 0) ld_timer = 3;
      end else chk("act_idle_zero", pe_act_in, 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
        else chk("res_data", res_data, exp_q.pop_front());
        res_log.push_back(res_data);
      end
      // Sticky load-done: rises 3 cycles after the last word, self-clears after 3.
      if (ld_timer > 0) begin
        ld_timer--;
        if (ld_timer == 0) begin pe_load_done = 1'b1; ld_hold = 3; end
      end else if (ld_hold > 0) begin
        ld_hold--;
        if (ld_hold == 0) pe_load_done = 1'b0;
      end
      // Row compute: result 4 cycles after start; done may be held by stuck_en after row 0.
      if (pe_start) c_timer = 4;
      if (c_timer > 0) begin
        c_timer--;
        if (c_timer == 0) begin
          s = 0;
          if (pe_row < NR) for (int j = 0; j < K; j++) s += int'(pe_w[j]) * int'(pe_a[pe_row * A + j]);
          pe_out = s[DW-1:0]; pe_row++; pe_compute_done = 1'b1; c_hold = 3;
        end
      end else if (pe_compute_done && !(stuck_en && pe_row == 1)) begin
        if (c_hold > 0) c_hold--;
        if (c_hold == 0) pe_compute_done = 1'b0;
      end
    end
  end

  task automatic issue(input int wb, input int ab, input bit reuse);
    int t;
    rd_addr_q.delete(); rd_cyc_q.delete(); wp_cyc.delete(); ap_cyc.delete();
    res_log.delete(); n_start = 0; n_done = 0;
    cur_eff = reuse && wk_valid; cur_wb = wb; cur_ab = ab;
    if (!cur_eff) begin
      for (int j = 0; j < KW; j++) tb_wk[j] = int'(mem[wb + j]);
      wk_valid = 1'b1;
    end
    for (int r = 0; r < NR; r++) exp_q.push_back(exp_row(ab, r));
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_wght_base = AW'(wb); cmd_act_base = AW'(ab); cmd_reuse_wght = reuse; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_reuse_wght = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    int t, exp_n, ok, first_a;
    t = 0;
    while (n_done == 0 && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_done_timeout"}, (n_done > 0), 1);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    // Expected GLB read trace: optional kernel burst then the tile burst, each gap-free.
    exp_n = (cur_eff ? 0 : KW) + AWD;
    chk({tag, "_rd_count"}, rd_addr_q.size(), exp_n);
    ok = (rd_addr_q.size() == exp_n);
    for (int i = 0; ok && i < exp_n; i++) begin
      if (!cur_eff && i < KW) begin
        if (rd_addr_q[i] != cur_wb + i || rd_cyc_q[i] != rd_cyc_q[0] + i) ok = 0;
      end else begin
        first_a = cur_eff ? 0 : KW;
        if (rd_addr_q[i] != cur_ab + i - first_a || rd_cyc_q[i] != rd_cyc_q[first_a] + i - first_a) ok = 0;
      end
    end
    chk({tag, "_rd_sequence"}, ok, 1);
    chk({tag, "_wpulse_count"}, wp_cyc.size(), cur_eff ? 0 : 1);
    chk({tag, "_apulse_count"}, ap_cyc.size(), 1);
    if (ok && wp_cyc.size() == 1 && !cur_eff) chk({tag, "_wpulse_latency"}, wp_cyc[0], rd_cyc_q[0] + 1);
    if (ok && ap_cyc.size() == 1) chk({tag, "_apulse_latency"}, ap_cyc[0], rd_cyc_q[cur_eff ? 0 : KW] + 1);
    ok = 1;
    for (int j = 0; j < KW; j++) if (int'(pe_w[j]) != tb_wk[j]) ok = 0;
    chk({tag, "_pe_kernel"}, ok, 1);
    ok = 1;
    for (int j = 0; j < AWD; j++) if (pe_a[j] != mem[cur_ab + j]) ok = 0;
    chk({tag, "_pe_tile"}, ok, 1);
    chk({tag, "_starts"}, n_start, NR);
    chk({tag, "_cmd_done_pulses"}, n_done, 1);
    chk({tag, "_results"}, res_log.size(), NR);
    chk({tag, "_idle"}, cmd_ready, 1);
    $display("cmd %s: wb=%0d ab=%0d reuse_eff=%0d reads=%0d starts=%0d results=%0d",
             tag, cur_wb, cur_ab, cur_eff, rd_addr_q.size(), n_start, res_log.size());
  endtask

  task automatic pin3(input string tag, input int r0, input int r1, input int r2);
    chk({tag, "_row0"}, (res_log.size() > 0) ? int'(res_log[0]) : -1, r0);
    chk({tag, "_row1"}, (res_log.size() > 1) ? int'(res_log[1]) : -1, r1);
    chk({tag, "_row2"}, (res_log.size() > 2) ? int'(res_log[2]) : -1, r2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_others_zero"}, |{glb_rd_en, glb_rd_addr, pe_filt_in, pe_act_in, pe_load_en_wght,
                                 pe_load_en_act, pe_start, res_valid, res_data, busy, cmd_done}, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < KW; i++) mem[i] = 16'd1;
    for (int i = 0; i < AWD; i++) mem[100 + i] = DW'(i);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Fresh load: unit kernel over 0..24.
    issue(0, 100, 1'b0);
    finish_cmd("fresh");
    pin3("fresh", 3, 18, 33);

    // New kernel in GLB, reuse must keep the old unit kernel.
    for (int i = 0; i < KW; i++) mem[i] = 16'd2;
    for (int i = 0; i < AWD; i++) mem[200 + i] = DW'(i + 1);
    issue(0, 200, 1'b1);
    finish_cmd("reuse");
    chk("reuse_first_addr", (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1, 200);
    pin3("reuse", 6, 21, 36);

    // Backpressure: FIFO of 2 fills, third start must wait for the consumer.
    res_ready = 1'b0;
    issue(0, 100, 1'b0);
    repeat (300) @(negedge clk);
    chk("bp_starts_stalled", n_start, 2);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_head", res_data, 6);
    res_ready = 1'b1;
    finish_cmd("backpressure");
    pin3("backpressure", 6, 36, 66);

    // Stuck compute_done after row 0: no further start until released.
    stuck_en = 1'b1;
    issue(0, 100, 1'b1);
    t = 0;
    while (!(pe_row >= 1 && pe_compute_done) && t < 2000) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    chk("stuck_starts", n_start, 1);
    chk("stuck_busy", busy, 1);
    stuck_en = 1'b0;
    finish_cmd("stuck");
    pin3("stuck", 6, 36, 66);

    // Reset in the middle of the activation burst.
    issue(0, 100, 1'b0);
    t = 0;
    while (!(glb_rd_en && glb_rd_addr == AW'(105)) && t < 2000) begin @(negedge clk); t++; end
    chk("abort_reached_a_rd", (glb_rd_en && glb_rd_addr == AW'(105)), 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    exp_q.delete();
    wk_valid = 1'b0;
    @(negedge clk);
    $display("cmd abort: reset applied during activation burst");

    // Reuse requested but no completed kernel since reset: full load expected.
    issue(0, 200, 1'b1);
    finish_cmd("post_reset");
    pin3("post_reset", 12, 42, 72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
